// File: rtl/axil_vga_slave.sv
// AXI4-Lite slave front end for the VGA text controller screen buffer.
// Terminates AW/W/B and AR/R channels and drives the buffer register port.
module axil_vga_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 12,
    parameter int ADDRLSB          = $clog2(C_AXI_DATA_WIDTH) - 3,
    parameter int MEM_BYTES        = 2400
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          s_axil_awvalid_i,
    output logic                          s_axil_awready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr_i,
    input  logic                          s_axil_wvalid_i,
    output logic                          s_axil_wready_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axil_wdata_i,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb_i,
    output logic                          s_axil_bvalid_o,
    input  logic                          s_axil_bready_i,
    output logic [1:0]                    s_axil_bresp_o,
    input  logic                          s_axil_arvalid_i,
    output logic                          s_axil_arready_o,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_araddr_i,
    output logic                          s_axil_rvalid_o,
    input  logic                          s_axil_rready_i,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axil_rdata_o,
    output logic [1:0]                    s_axil_rresp_o,
    output logic                          mem_wen_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   mem_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] mem_wstrb_o,
    output logic                          mem_rreq_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   mem_raddr_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = C_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;
    localparam logic [1:0] R_RESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [AW-1:0] LSB_MASK  = AW'((1 << ADDRLSB) - 1);
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_BYTES);

    logic          r_aw_full;
    logic [AW-1:0] r_awaddr;
    logic          r_w_full;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_mem_wen;
    logic [AW-1:0] r_mem_waddr;
    logic [DW-1:0] r_mem_wdata;
    logic [SW-1:0] r_mem_wstrb;

    logic [1:0]    r_state;
    logic [AW-1:0] r_araddr;
    logic          r_rreq;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_rresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_wr_issue;
    logic w_wr_in_range;

    assign w_aw_hs = s_axil_awvalid_i && !r_aw_full;
    assign w_w_hs  = s_axil_wvalid_i && !r_w_full;
    assign w_ar_hs = s_axil_arvalid_i && (r_state == R_IDLE);

    // Reads win the buffer port: a write waits out the request cycle.
    assign w_wr_issue = r_aw_full && r_w_full && !r_bvalid
                        && (r_state != R_REQ);
    assign w_wr_in_range = (r_awaddr < MEM_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_full   <= 1'b0;
            r_awaddr    <= '0;
            r_w_full    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_mem_wen   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_wen <= 1'b0;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= s_axil_awaddr_i & ~LSB_MASK;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axil_wdata_i;
                r_wstrb  <= s_axil_wstrb_i;
            end
            if (r_bvalid && s_axil_bready_i) begin
                r_bvalid <= 1'b0;
            end
            if (w_wr_issue) begin
                r_aw_full   <= 1'b0;
                r_w_full    <= 1'b0;
                r_bvalid    <= 1'b1;
                r_mem_wen   <= w_wr_in_range;
                r_mem_waddr <= r_awaddr;
                r_mem_wdata <= r_wdata;
                r_mem_wstrb <= r_wstrb;
                r_bresp     <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= R_IDLE;
            r_araddr <= '0;
            r_rreq   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rreq <= 1'b0;
            unique case (r_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr <= s_axil_araddr_i & ~LSB_MASK;
                        r_rreq   <= 1'b1;
                        r_state  <= R_REQ;
                    end
                end
                R_REQ: begin
                    r_state <= R_WAIT;
                end
                R_WAIT: begin
                    r_rvalid <= 1'b1;
                    // Out-of-range reads still hit the port; data is dropped.
                    if (r_araddr < MEM_LIMIT) begin
                        r_rdata <= mem_rdata_i;
                        r_rresp <= RESP_OKAY;
                    end else begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end
                    r_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_axil_rready_i) begin
                        r_rvalid <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axil_awready_o = !r_aw_full;
    assign s_axil_wready_o  = !r_w_full;
    assign s_axil_bvalid_o  = r_bvalid;
    assign s_axil_bresp_o   = r_bresp;
    assign s_axil_arready_o = (r_state == R_IDLE);
    assign s_axil_rvalid_o  = r_rvalid;
    assign s_axil_rdata_o   = r_rdata;
    assign s_axil_rresp_o   = r_rresp;
    assign mem_wen_o        = r_mem_wen;
    assign mem_waddr_o      = r_mem_waddr;
    assign mem_wdata_o      = r_mem_wdata;
    assign mem_wstrb_o      = r_mem_wstrb;
    assign mem_rreq_o       = r_rreq;
    assign mem_raddr_o      = r_araddr;

endmodule

// File: tb/tb_axil_vga_slave.sv
// Bench for axil_vga_slave: directed vector table plus hand sequences,
// with a one-cycle-latency screen buffer model on the memory port.
module tb_axil_vga_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [11:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        m_wen;
    logic [11:0] m_waddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rreq;
    logic [11:0] m_raddr;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int rreq_cnt = 0;

    logic [31:0] mem [0:1023];

    axil_vga_slave dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_bresp_o   (bresp),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_araddr_i  (araddr),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .mem_wen_o        (m_wen),
        .mem_waddr_o      (m_waddr),
        .mem_wdata_o      (m_wdata),
        .mem_wstrb_o      (m_wstrb),
        .mem_rreq_o       (m_rreq),
        .mem_raddr_o      (m_raddr),
        .mem_rdata_i      (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (m_wen) begin
            for (int b = 0; b < 4; b++)
                if (m_wstrb[b])
                    mem[m_waddr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        if (m_rreq) m_rdata <= mem[m_raddr[11:2]];
        if (m_wen) wen_cnt <= wen_cnt + 1;
        if (m_rreq) rreq_cnt <= rreq_cnt + 1;
    end

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        pulse;
        logic [11:0] eaddr;
        logic [31:0] erdata;
        logic [1:0]  eresp;
    } vec_t;

    vec_t vt [13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".awready"}, 32'(awready), 32'd1);
        chk({tag, ".wready"}, 32'(wready), 32'd1);
        chk({tag, ".arready"}, 32'(arready), 32'd1);
        chk({tag, ".bvalid"}, 32'(bvalid), 32'd0);
        chk({tag, ".rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, ".bresp"}, 32'(bresp), 32'd0);
        chk({tag, ".rresp"}, 32'(rresp), 32'd0);
        chk({tag, ".rdata"}, rdata, 32'd0);
        chk({tag, ".wen"}, 32'(m_wen), 32'd0);
        chk({tag, ".rreq"}, 32'(m_rreq), 32'd0);
        chk({tag, ".waddr"}, 32'(m_waddr), 32'd0);
        chk({tag, ".wdata"}, m_wdata, 32'd0);
        chk({tag, ".wstrb"}, 32'(m_wstrb), 32'd0);
        chk({tag, ".raddr"}, 32'(m_raddr), 32'd0);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic ep,
                            input logic [11:0] ea, input logic [1:0] er,
                            input string tag);
        int n0 = wen_cnt;
        awvalid = 1'b1; awaddr = a;
        wvalid = 1'b1; wdata = d; wstrb = s;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, ".awready_busy"}, 32'(awready), 32'd0);
        tick;
        chk({tag, ".wen"}, 32'(m_wen), 32'(ep));
        chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, ".bresp"}, 32'(bresp), 32'(er));
        if (ep) begin
            chk({tag, ".waddr"}, 32'(m_waddr), 32'(ea));
            chk({tag, ".wdata"}, m_wdata, d);
            chk({tag, ".wstrb"}, 32'(m_wstrb), 32'(s));
        end
        tick;
        chk({tag, ".bhold"}, 32'(bvalid), 32'd1);
        chk({tag, ".wen_end"}, 32'(m_wen), 32'd0);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        chk({tag, ".bclear"}, 32'(bvalid), 32'd0);
        chk({tag, ".wen_cnt"}, 32'(wen_cnt - n0), 32'(ep));
    endtask

    task automatic do_read(input logic [11:0] a, input logic [11:0] ea,
                           input logic [31:0] ed, input logic [1:0] er,
                           input string tag);
        int n0 = rreq_cnt;
        arvalid = 1'b1; araddr = a;
        tick;
        arvalid = 1'b0;
        chk({tag, ".rreq"}, 32'(m_rreq), 32'd1);
        chk({tag, ".raddr"}, 32'(m_raddr), 32'(ea));
        chk({tag, ".arready_busy"}, 32'(arready), 32'd0);
        tick;
        chk({tag, ".rreq_end"}, 32'(m_rreq), 32'd0);
        chk({tag, ".rvalid_early"}, 32'(rvalid), 32'd0);
        tick;
        chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, ".rdata"}, rdata, ed);
        chk({tag, ".rresp"}, 32'(rresp), 32'(er));
        rready = 1'b1;
        tick;
        rready = 1'b0;
        chk({tag, ".rclear"}, 32'(rvalid), 32'd0);
        chk({tag, ".rreq_cnt"}, 32'(rreq_cnt - n0), 32'd1);
    endtask

    initial begin
        int n0;
        logic [31:0] held;

        vt[0]  = '{1'b0, 12'h010, 32'h41424344, 4'hF, 1'b1, 12'h010, 32'h0, 2'b00};
        vt[1]  = '{1'b0, 12'h024, 32'hA5A5A5A5, 4'h3, 1'b1, 12'h024, 32'h0, 2'b00};
        vt[2]  = '{1'b0, 12'h960, 32'hCAFEF00D, 4'hF, 1'b0, 12'h000, 32'h0, 2'b10};
        vt[3]  = '{1'b0, 12'h95F, 32'hDEADBEEF, 4'hF, 1'b1, 12'h95C, 32'h0, 2'b00};
        vt[4]  = '{1'b0, 12'h028, 32'hFFFFFFFF, 4'h0, 1'b1, 12'h028, 32'h0, 2'b00};
        vt[5]  = '{1'b0, 12'h020, 32'h00000058, 4'hF, 1'b1, 12'h020, 32'h0, 2'b00};
        vt[6]  = '{1'b0, 12'h030, 32'h00000011, 4'hF, 1'b1, 12'h030, 32'h0, 2'b00};
        vt[7]  = '{1'b1, 12'h010, 32'h0, 4'h0, 1'b1, 12'h010, 32'h41424344, 2'b00};
        vt[8]  = '{1'b1, 12'h026, 32'h0, 4'h0, 1'b1, 12'h024, 32'h0000A5A5, 2'b00};
        vt[9]  = '{1'b1, 12'h95C, 32'h0, 4'h0, 1'b1, 12'h95C, 32'hDEADBEEF, 2'b00};
        vt[10] = '{1'b1, 12'h960, 32'h0, 4'h0, 1'b1, 12'h960, 32'h00000000, 2'b10};
        vt[11] = '{1'b1, 12'h028, 32'h0, 4'h0, 1'b1, 12'h028, 32'h00000000, 2'b00};
        vt[12] = '{1'b1, 12'h020, 32'h0, 4'h0, 1'b1, 12'h020, 32'h00000058, 2'b00};

        tick;
        tick;
        chk_reset("por");
        rst = 1'b0;
        tick;

        for (int i = 0; i < 13; i++) begin
            if (vt[i].rd)
                do_read(vt[i].addr, vt[i].eaddr, vt[i].erdata,
                        vt[i].eresp, $sformatf("v%0d", i));
            else
                do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].pulse,
                         vt[i].eaddr, vt[i].eresp, $sformatf("v%0d", i));
        end

        // W leads AW by three cycles
        n0 = wen_cnt;
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        tick;
        wvalid = 1'b0;
        chk("wfirst.wready", 32'(wready), 32'd0);
        tick;
        tick;
        chk("wfirst.nowen", 32'(m_wen), 32'd0);
        chk("wfirst.nob", 32'(bvalid), 32'd0);
        awvalid = 1'b1; awaddr = 12'h013;
        tick;
        awvalid = 1'b0;
        chk("wfirst.awready", 32'(awready), 32'd0);
        tick;
        chk("wfirst.wen", 32'(m_wen), 32'd1);
        chk("wfirst.waddr", 32'(m_waddr), 32'h010);
        chk("wfirst.wdata", m_wdata, 32'h12345678);
        chk("wfirst.bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        chk("wfirst.once", 32'(wen_cnt - n0), 32'd1);
        chk("wfirst.wready_back", 32'(wready), 32'd1);

        // read held while rready stays low
        n0 = rreq_cnt;
        arvalid = 1'b1; araddr = 12'h020;
        tick;
        arvalid = 1'b0;
        tick;
        tick;
        chk("rhold.rvalid", 32'(rvalid), 32'd1);
        chk("rhold.rdata", rdata, 32'h58);
        held = rdata;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("rhold.stable%0d", k),
                {rdata[31:2], rvalid, arready}, {held[31:2], 1'b1, 1'b0});
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        chk("rhold.rclear", 32'(rvalid), 32'd0);
        chk("rhold.arready", 32'(arready), 32'd1);
        chk("rhold.once", 32'(rreq_cnt - n0), 32'd1);

        // write and read to one word in the same cycle
        awvalid = 1'b1; awaddr = 12'h030;
        wvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h030;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw.rreq", 32'(m_rreq), 32'd1);
        chk("rw.wen0", 32'(m_wen), 32'd0);
        tick;
        chk("rw.wen1", 32'(m_wen), 32'd0);
        tick;
        chk("rw.wen2", 32'(m_wen), 32'd1);
        chk("rw.rvalid", 32'(rvalid), 32'd1);
        chk("rw.old", rdata, 32'h11);
        bready = 1'b1; rready = 1'b1;
        tick;
        bready = 1'b0; rready = 1'b0;
        chk("rw.bclear", 32'(bvalid), 32'd0);
        do_read(12'h030, 12'h030, 32'h22, 2'b00, "rw.new");

        // reset while AW held and read FSM waits for data
        awvalid = 1'b1; awaddr = 12'h040;
        tick;
        awvalid = 1'b0;
        arvalid = 1'b1; araddr = 12'h044;
        tick;
        arvalid = 1'b0;
        tick;
        chk("mid.awfull", 32'(awready), 32'd0);
        rst = 1'b1;
        tick;
        chk_reset("mid");
        rst = 1'b0;
        n0 = wen_cnt;
        wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF;
        tick;
        wvalid = 1'b0;
        tick;
        tick;
        tick;
        chk("mid.nowen", 32'(wen_cnt - n0), 32'd0);
        chk("mid.nob", 32'(bvalid), 32'd0);
        chk("mid.norv", 32'(rvalid), 32'd0);
        chk("mid.awready", 32'(awready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
